// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage. It holds the architectural HI/LO
// registers and takes WIDTH cycles per MULT/MULTU/DIV/DIVU.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             I_MD_START,
  input  logic [2:0]       I_MD_OP,
  input  logic [WIDTH-1:0] I_MD_A,
  input  logic [WIDTH-1:0] I_MD_B,
  input  logic             I_HILO_USE,
  output logic [WIDTH-1:0] O_HI,
  output logic [WIDTH-1:0] O_LO,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic             O_STALL
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   raw_a;
  logic [WIDTH-1:0]   hi, lo;
  logic               done;
  logic               is_div, neg_q, neg_r, div_zero;

  logic               signed_op, is_iter_op, a_neg, b_neg, last_iter, rem_ge;
  logic [WIDTH-1:0]   abs_a, abs_b, rem_sub, res_hi, res_lo;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, acc_step, prod;

  always_comb begin
    signed_op  = (I_MD_OP == OP_MULT) || (I_MD_OP == OP_DIV);
    is_iter_op = (I_MD_OP == OP_MULT) || (I_MD_OP == OP_MULTU) ||
                 (I_MD_OP == OP_DIV)  || (I_MD_OP == OP_DIVU);
    a_neg      = signed_op & I_MD_A[WIDTH-1];
    b_neg      = signed_op & I_MD_B[WIDTH-1];
    abs_a      = a_neg ? -I_MD_A : I_MD_A;
    abs_b      = b_neg ? -I_MD_B : I_MD_B;
    last_iter  = (cnt == CNT_W'(WIDTH-1));
  end

  // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
  // Divide: acc = {partial remainder, remaining dividend bits / quotient}; restoring step.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    rem_ge   = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd};
    rem_sub  = acc[2*WIDTH-2:WIDTH-1] - opnd;
    div_next = rem_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    acc_step = is_div ? div_next : mul_next;
  end

  // Sign correction of the final iteration's value, plus the divide-by-zero override.
  always_comb begin
    prod   = neg_q ? -acc_step : acc_step;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = raw_a;
        res_lo = {WIDTH{1'b1}};
      end else begin
        res_hi = neg_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        res_lo = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ENABLE && I_MD_START && is_iter_op) state_next = RUN;
      RUN:  if (ENABLE && last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      raw_a    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (ENABLE) begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (I_MD_START) begin
          case (I_MD_OP)
            OP_MULT, OP_MULTU: begin
              opnd     <= abs_a;
              acc      <= {{WIDTH{1'b0}}, abs_b};
              is_div   <= 1'b0;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= 1'b0;
              div_zero <= 1'b0;
              cnt      <= '0;
            end
            OP_DIV, OP_DIVU: begin
              opnd     <= abs_b;
              acc      <= {{WIDTH{1'b0}}, abs_a};
              raw_a    <= I_MD_A;
              is_div   <= 1'b1;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= (I_MD_B == '0);
              cnt      <= '0;
            end
            OP_MTHI: hi <= I_MD_A;
            OP_MTLO: lo <= I_MD_A;
            default: ;
          endcase
        end
      end else begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
        if (last_iter) begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
      end
    end
  end

  assign O_HI    = hi;
  assign O_LO    = lo;
  assign O_BUSY  = (state == RUN);
  assign O_DONE  = done;
  assign O_STALL = O_BUSY & I_HILO_USE;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed and random mul/div ops compared with a plain
// arithmetic reference model, plus stall, MTHI/MTLO, reset and enable-freeze scenarios.
module tb_ex_muldiv_unit;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  logic        clk = 1'b0;
  logic        reset, enable, md_start, hilo_use;
  logic [2:0]  md_op;
  logic [31:0] md_a, md_b;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_hi, exp_lo;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(clk), .RESET(reset), .ENABLE(enable), .I_MD_START(md_start),
    .I_MD_OP(md_op), .I_MD_A(md_a), .I_MD_B(md_b), .I_HILO_USE(hilo_use),
    .O_HI(hi), .O_LO(lo), .O_BUSY(busy), .O_DONE(done), .O_STALL(stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] m_hi, output logic [31:0] m_lo);
    longint sa, sb, sr;
    longint unsigned ua, ub, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    m_hi = 32'h0;
    m_lo = 32'h0;
    case (op)
      OP_MULT:  begin sr = sa * sb; m_hi = sr[63:32]; m_lo = sr[31:0]; end
      OP_MULTU: begin ur = ua * ub; m_hi = ur[63:32]; m_lo = ur[31:0]; end
      OP_DIV, OP_DIVU: begin
        if (b == 32'h0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
          sr = sa / sb; m_lo = sr[31:0];
          sr = sa % sb; m_hi = sr[31:0];
        end else begin
          ur = ua / ub; m_lo = ur[31:0];
          ur = ua % ub; m_hi = ur[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Issues one op and follows it to completion, optionally freezing ENABLE for 5 cycles.
  task automatic exec_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int freeze_at, output int busy_cyc, output int done_cnt);
    md_op = op; md_a = a; md_b = b; md_start = 1'b1;
    step();
    md_start = 1'b0;
    busy_cyc = 0;
    done_cnt = 0;
    for (int guard = 0; guard < 200 && busy; guard++) begin
      if (done) done_cnt++;
      busy_cyc++;
      if (busy_cyc == freeze_at) enable = 1'b0;
      if (busy_cyc == freeze_at + 5) enable = 1'b1;
      step();
    end
    enable = 1'b1;
    if (done) done_cnt++;
    step();
    if (done) done_cnt++;
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int freeze_at, input int exp_busy);
    int bc, dc;
    model(op, a, b, exp_hi, exp_lo);
    exec_op(op, a, b, freeze_at, bc, dc);
    vectors++;
    if (bc !== exp_busy) begin
      miscompares++;
      $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, bc, exp_busy);
    end
    vectors++;
    if (dc !== 1) begin
      miscompares++;
      $display("[TB] FAIL %s done_pulses: got %0d expected 1", name, dc);
    end
    vectors++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      miscompares++;
      $display("[TB] FAIL %s op=%0d a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
               name, op, a, b, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; md_start = 1'b0; hilo_use = 1'b0;
    md_op = OP_NONE; md_a = '0; md_b = '0;
    step(); step();
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got hi=%h lo=%h busy=%b done=%b expected all zero",
               hi, lo, busy, done);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_directed();
    check_op("multu_ffff", OP_MULTU, 32'h0000_FFFF, 32'h0001_0001, 0, 32);
    check_op("mult_neg2x3", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 0, 32);
    check_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, 32);
    check_op("divu_by_zero", OP_DIVU, 32'd100, 32'h0, 0, 32);
    check_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32);
    check_op("div_by_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'h0, 0, 32);
    check_op("mult_minint", OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 32);
    check_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      check_op("random", op, a, b, 0, 32);
    end
  endtask

  task automatic test_stall_and_restart();
    int bc;
    logic [31:0] e_hi, e_lo;
    model(OP_DIVU, 32'd1000, 32'd7, e_hi, e_lo);
    hilo_use = 1'b1;
    md_op = OP_DIVU; md_a = 32'd1000; md_b = 32'd7; md_start = 1'b1;
    step();
    md_start = 1'b0;
    bc = 0;
    for (int guard = 0; guard < 200 && busy; guard++) begin
      bc++;
      vectors++;
      if (stall !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stall_while_busy cycle %0d: got %b expected 1", bc, stall);
      end
      if (bc == 12) begin
        hilo_use = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL stall_no_use: got %b expected 0", stall);
        end
        hilo_use = 1'b1;
      end
      md_start = (bc == 5) || (bc == 8);
      md_op = (bc == 8) ? OP_MTHI : OP_MULTU;
      md_a = 32'hDEAD_BEEF; md_b = 32'h0000_0100;
      step();
    end
    md_start = 1'b0;
    vectors++;
    if (bc !== 32 || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL restart_ignored timing: got busy=%0d done=%b expected 32 and 1", bc, done);
    end
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_at_done: got %b expected 0", stall);
    end
    vectors++;
    if (hi !== e_hi || lo !== e_lo) begin
      miscompares++;
      $display("[TB] FAIL restart_ignored result: got hi=%h lo=%h expected hi=%h lo=%h",
               hi, lo, e_hi, e_lo);
    end
    step();
    vectors++;
    if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL after_done: got stall=%b busy=%b done=%b expected 0", stall, busy, done);
    end
    hilo_use = 1'b0;
    exp_hi = e_hi;
    exp_lo = e_lo;
  endtask

  task automatic test_mthi_mtlo();
    logic saw_busy;
    saw_busy = 1'b0;
    md_start = 1'b1; md_op = OP_MTHI; md_a = 32'h1234_5678;
    step();
    saw_busy |= busy;
    vectors++;
    if (hi !== 32'h1234_5678 || lo !== exp_lo) begin
      miscompares++;
      $display("[TB] FAIL mthi: got hi=%h lo=%h expected hi=12345678 lo=%h", hi, lo, exp_lo);
    end
    md_op = OP_MTLO; md_a = 32'h9ABC_DEF0;
    step();
    saw_busy |= busy;
    vectors++;
    if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      miscompares++;
      $display("[TB] FAIL mtlo: got hi=%h lo=%h expected hi=12345678 lo=9abcdef0", hi, lo);
    end
    md_op = OP_RSVD; md_a = 32'h5555_5555;
    step();
    saw_busy |= busy;
    md_op = OP_NONE;
    step();
    saw_busy |= busy;
    md_start = 1'b0;
    step();
    saw_busy |= busy;
    vectors++;
    if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || saw_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL noop_ops: got hi=%h lo=%h busy_seen=%b expected 12345678 9abcdef0 0",
               hi, lo, saw_busy);
    end
    exp_hi = 32'h1234_5678;
    exp_lo = 32'h9ABC_DEF0;
  endtask

  task automatic test_enable_idle();
    enable = 1'b0;
    md_start = 1'b1; md_op = OP_MTHI; md_a = 32'hAAAA_0000;
    step();
    md_op = OP_MULT;
    step();
    md_start = 1'b0;
    vectors++;
    if (hi !== exp_hi || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL enable_low_idle: got hi=%h busy=%b expected hi=%h busy=0", hi, busy, exp_hi);
    end
    enable = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_run();
    logic saw_activity;
    md_op = OP_MULT; md_a = 32'h0123_4567; md_b = 32'hFEDC_BA98; md_start = 1'b1;
    step();
    md_start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    #1;
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_run: got hi=%h lo=%h busy=%b done=%b expected all zero",
               hi, lo, busy, done);
    end
    step();
    reset = 1'b0;
    saw_activity = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      saw_activity |= busy | done;
    end
    vectors++;
    if (saw_activity !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL aborted_op_resumed: got activity=%b hi=%h lo=%h expected 0 0 0",
               saw_activity, hi, lo);
    end
  endtask

  task automatic test_enable_freeze();
    check_op("freeze_mult", OP_MULT, 32'hFFFF_8001, 32'h0007_ABCD, 10, 37);
    check_op("freeze_div", OP_DIV, 32'h7FFF_1234, 32'hFFFF_FFFD, 20, 37);
  endtask

  task automatic test_back_to_back();
    check_op("b2b_divu", OP_DIVU, $urandom, 32'($urandom_range(1, 65535)), 0, 32);
    check_op("b2b_mult", OP_MULT, $urandom, $urandom, 0, 32);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall_and_restart();
    test_mthi_mtlo();
    test_enable_idle();
    test_reset_mid_run();
    test_enable_freeze();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded mul/div operation plus the rs/rt operand values from ID/EX.
- Executes MULT, MULTU, DIV, DIVU over multiple cycles, and MTHI/MTLO in one cycle; holds the architectural HI/LO registers.
- Raises a stall request to the hazard unit while a result is pending and EX needs HI/LO.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- ENABLE  input  1  global pipeline enable; low freezes all state
- I_MD_START  input  1  EX holds a valid mul/div/mt op this cycle
- I_MD_OP  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (no-op)
- I_MD_A  input  WIDTH  rs value (multiplicand/dividend/MT source)
- I_MD_B  input  WIDTH  rt value (multiplier/divisor)
- I_HILO_USE  input  1  EX instruction reads HI/LO (MFHI/MFLO) or is a new mul/div/mt op
- O_HI  output  WIDTH  HI register
- O_LO  output  WIDTH  LO register
- O_BUSY  output  1  iterative operation in progress
- O_DONE  output  1  one-cycle pulse when HI/LO receive an iterative result
- O_STALL  output  1  combinational: O_BUSY & I_HILO_USE

Behaviour:
- Reset (async, any time including mid-operation): O_HI=0, O_LO=0, O_BUSY=0, O_DONE=0, counter=0, operation aborted, state IDLE.
- ENABLE=0: no register changes (counter, HI/LO, state, O_DONE all hold); O_STALL is still computed.
- States: IDLE, RUN.
- IDLE + ENABLE + I_MD_START:
  - MULT/MULTU/DIV/DIVU: latch operands; for signed ops latch absolute values and record result sign(s); counter=0; go to RUN; O_BUSY=1 from the next cycle.
  - MTHI: HI<=I_MD_A at that edge; LO unchanged; stay IDLE.
  - MTLO: LO<=I_MD_A at that edge; HI unchanged; stay IDLE.
  - OP 000/111: ignored.
- RUN, each enabled edge, one iteration:
  - Multiply: shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Counter increments.
- Completion: on the edge where counter reaches WIDTH-1 (the WIDTH-th iteration edge after start), write the sign-corrected result to HI/LO, drive O_BUSY=0 and O_DONE=1 (for exactly one cycle), and return to IDLE.
- Latency: O_BUSY high for exactly WIDTH cycles; results are visible on O_HI/O_LO in the cycle after the last iteration.
- Multiply result: {HI,LO} = 64-bit product. MULT is signed, MULTU unsigned.
- Divide result: LO=quotient, HI=remainder.
  - DIV: quotient sign = signA xor signB; remainder takes the dividend's sign.
  - DIVU: unsigned.
- Divide by zero (DIV or DIVU): LO=32'hFFFFFFFF, HI=I_MD_A as latched. Still takes the full WIDTH cycles, with the same timing as a normal divide.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- I_MD_START while in RUN: ignored; no restart, no HI/LO change. The hazard unit guarantees this does not occur via O_STALL.
- MTHI/MTLO while in RUN: ignored (same rule).
- O_STALL is purely combinational; it never depends on I_MD_OP.
- HI/LO are never written except at completion, at an MTHI/MTLO edge, or at reset.

Test Plan:
- Reset, then MULTU A=0x0000FFFF, B=0x00010001 -> O_BUSY high for 32 cycles; O_DONE pulses once; HI=0x00000000, LO=0xFFFFFFFF.
- MULT A=0xFFFFFFFE (-2), B=0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; then DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 -> after 32 busy cycles LO=0xFFFFFFFF, HI=100; then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- During a DIVU run, assert I_HILO_USE -> O_STALL=1 every busy cycle and 0 in the cycle after O_DONE. A second I_MD_START mid-run is ignored: the result equals the first op's result.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated one edge each; O_BUSY never asserted.
- Start a MULT, assert RESET at cycle 10 -> HI=LO=0, O_BUSY=0 immediately, no O_DONE. Hold ENABLE low for 5 cycles mid-run of another op -> O_BUSY lasts 37 cycles with a correct result.
